// File: rtl/tl_ctrl_pkg.sv
// Shared bit indices and widths for the traffic-light controller and its datapath.
// The phase encoding and watchdog limit stay local to tl_ctrl.
package tl_ctrl_pkg;

   localparam int unsigned STATE_W      = 4;
   localparam int unsigned STATE_DONE_W = 7;

   // curr_state one-hot indices
   localparam int unsigned S_G    = 0;
   localparam int unsigned S_Y    = 1;
   localparam int unsigned S_R    = 2;
   localparam int unsigned S_NONE = 3;

   // done_state indices
   localparam int unsigned DONE_G1    = 0;
   localparam int unsigned DONE_G2    = 1;
   localparam int unsigned DONE_G3    = 2;
   localparam int unsigned DONE_Y     = 3;
   localparam int unsigned DONE_R     = 4;
   localparam int unsigned DONE_NONE1 = 5;
   localparam int unsigned DONE_NONE2 = 6;

   localparam int unsigned WDOG_W = 11;

   function automatic logic [STATE_W-1:0] state_onehot(input int unsigned idx);
      state_onehot = STATE_W'(1) << idx;
   endfunction

endpackage

// File: rtl/tl_edge_det.sv
// Registered rising-edge detector: rise is high while din is high and was low last cycle.
module tl_edge_det
   import tl_ctrl_pkg::*;
#(
   parameter int unsigned Width = STATE_DONE_W
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [Width-1:0] din,
   output logic [Width-1:0] rise
);

   logic [Width-1:0] prev_q, prev_d;

   always_comb begin
      prev_d = din;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         prev_q <= '0;
      end else begin
         prev_q <= prev_d;
      end
   end

   assign rise = din & ~prev_q;

endmodule

// File: rtl/tl_ctrl.sv
// Traffic-light phase sequencer with pass restart and a per-phase watchdog.
// All outputs are registered alongside the phase register.
module tl_ctrl
   import tl_ctrl_pkg::*;
#(
   parameter int unsigned WDOG_MAX = 2047
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    pass,
   input  logic [STATE_DONE_W-1:0] done_state,
   output logic [STATE_W-1:0]      curr_state,
   output logic                    dp_cnt_rst,
   output logic                    red_done,
   output logic                    R,
   output logic                    G,
   output logic                    Y,
   output logic                    fault
);

   typedef enum logic [2:0] {
      P_G1, P_N1, P_G2, P_N2, P_G3, P_Y, P_R, P_FAULT
   } phase_e;

   localparam logic [WDOG_W-1:0] WdogMax = WDOG_MAX[WDOG_W-1:0];
   localparam logic [WDOG_W-1:0] WdogSat = '1;

   phase_e               phase_q, phase_d, adv_phase;
   logic [WDOG_W-1:0]    wdog_q, wdog_d;
   logic [STATE_W-1:0]   curr_state_q, curr_state_d;
   logic                 dp_cnt_rst_q, dp_cnt_rst_d;
   logic                 red_done_q, red_done_d;
   logic                 r_q, r_d, g_q, g_d, y_q, y_d;
   logic                 fault_q, fault_d;
   logic                 entered;
   logic                 adv;
   logic [STATE_DONE_W-1:0] done_rise;

   tl_edge_det #(
      .Width (STATE_DONE_W)
   ) u_edge_det (
      .clk   (clk),
      .reset (reset),
      .din   (done_state),
      .rise  (done_rise)
   );

   // Each phase listens only to its own done bit.
   always_comb begin
      adv       = 1'b0;
      adv_phase = phase_q;
      unique case (phase_q)
         P_G1:    begin adv = done_rise[DONE_G1];    adv_phase = P_N1; end
         P_N1:    begin adv = done_rise[DONE_NONE1]; adv_phase = P_G2; end
         P_G2:    begin adv = done_rise[DONE_G2];    adv_phase = P_N2; end
         P_N2:    begin adv = done_rise[DONE_NONE2]; adv_phase = P_G3; end
         P_G3:    begin adv = done_rise[DONE_G3];    adv_phase = P_Y;  end
         P_Y:     begin adv = done_rise[DONE_Y];     adv_phase = P_R;  end
         P_R:     begin adv = done_rise[DONE_R];     adv_phase = P_G1; end
         P_FAULT: begin adv = 1'b0;                  adv_phase = P_FAULT; end
         default: begin adv = 1'b0;                  adv_phase = P_FAULT; end
      endcase
   end

   always_comb begin
      phase_d    = phase_q;
      entered    = 1'b0;
      red_done_d = 1'b0;
      if (phase_q != P_FAULT) begin
         if (wdog_q == WdogMax) begin
            phase_d = P_FAULT;
            entered = 1'b1;
         end else if (pass && (phase_q != P_G1)) begin
            phase_d    = P_G1;
            entered    = 1'b1;
            red_done_d = 1'b1;
         end else if (adv) begin
            phase_d    = adv_phase;
            entered    = 1'b1;
            red_done_d = (phase_q == P_R);
         end
      end

      if (entered) begin
         wdog_d = '0;
      end else if (wdog_q == WdogSat) begin
         wdog_d = wdog_q;
      end else begin
         wdog_d = wdog_q + 1'b1;
      end

      dp_cnt_rst_d = entered;
      fault_d      = fault_q | (phase_d == P_FAULT);

      curr_state_d = '0;
      r_d          = 1'b0;
      g_d          = 1'b0;
      y_d          = 1'b0;
      unique case (phase_d)
         P_G1, P_G2, P_G3: begin curr_state_d = state_onehot(S_G);    g_d = 1'b1; end
         P_N1, P_N2:       begin curr_state_d = state_onehot(S_NONE);             end
         P_Y:              begin curr_state_d = state_onehot(S_Y);    y_d = 1'b1; end
         P_R, P_FAULT:     begin curr_state_d = state_onehot(S_R);    r_d = 1'b1; end
         default:          begin curr_state_d = state_onehot(S_R);    r_d = 1'b1; end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         phase_q      <= P_G1;
         wdog_q       <= '0;
         curr_state_q <= state_onehot(S_G);
         dp_cnt_rst_q <= 1'b1;
         red_done_q   <= 1'b0;
         r_q          <= 1'b0;
         g_q          <= 1'b1;
         y_q          <= 1'b0;
         fault_q      <= 1'b0;
      end else begin
         phase_q      <= phase_d;
         wdog_q       <= wdog_d;
         curr_state_q <= curr_state_d;
         dp_cnt_rst_q <= dp_cnt_rst_d;
         red_done_q   <= red_done_d;
         r_q          <= r_d;
         g_q          <= g_d;
         y_q          <= y_d;
         fault_q      <= fault_d;
      end
   end

   assign curr_state = curr_state_q;
   assign dp_cnt_rst = dp_cnt_rst_q;
   assign red_done   = red_done_q;
   assign R          = r_q;
   assign G          = g_q;
   assign Y          = y_q;
   assign fault      = fault_q;

endmodule

// File: tb/tb_tl_ctrl.sv
// Directed bench for tl_ctrl: phase order, edge qualification, pass, watchdog and reset.
module tb_tl_ctrl;
   import tl_ctrl_pkg::*;

   logic       clk = 1'b0;
   logic       reset;
   logic       pass;
   logic [6:0] done_state;
   logic [3:0] curr_state;
   logic       dp_cnt_rst, red_done, R, G, Y, fault;

   int n_checks = 0;
   int n_pass   = 0;

   // Packed view: {curr_state, R, G, Y, dp_cnt_rst, red_done, fault}
   localparam logic [9:0] E_G = {4'b0001, 3'b010, 3'b000};
   localparam logic [9:0] E_N = {4'b1000, 3'b000, 3'b000};
   localparam logic [9:0] E_Y = {4'b0010, 3'b001, 3'b000};
   localparam logic [9:0] E_R = {4'b0100, 3'b100, 3'b000};
   localparam logic [9:0] RST = 10'b100;
   localparam logic [9:0] RD  = 10'b010;
   localparam logic [9:0] FLT = 10'b001;

   tl_ctrl dut (
      .clk        (clk),
      .reset      (reset),
      .pass       (pass),
      .done_state (done_state),
      .curr_state (curr_state),
      .dp_cnt_rst (dp_cnt_rst),
      .red_done   (red_done),
      .R          (R),
      .G          (G),
      .Y          (Y),
      .fault      (fault)
   );

   always #5 clk = ~clk;

   function automatic logic [9:0] outs();
      return {curr_state, R, G, Y, dp_cnt_rst, red_done, fault};
   endfunction

   task automatic check(input string tag, input logic [9:0] obs, input logic [9:0] exp);
      n_checks++;
      if (obs !== exp) begin
         $display("FAIL %s: got %b expected %b", tag, obs, exp);
      end else begin
         n_pass++;
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Raise one done bit and expect the entry outputs of the next phase.
   task automatic step(input int b, input logic [9:0] exp, input string tag);
      done_state[b] = 1'b1;
      tick();
      check(tag, outs(), exp | RST);
   endtask

   initial begin
      reset      = 1'b1;
      pass       = 1'b0;
      done_state = '0;
      tick();
      tick();
      check("reset_values", outs(), E_G | RST);
      reset = 1'b0;
      tick();
      check("rst_release", outs(), E_G);
      repeat (8) tick();

      // Full sequence
      step(DONE_G1, E_N, "g1_to_n1");
      tick();
      check("n1_rst_drop", outs(), E_N);
      step(DONE_NONE1, E_G,      "n1_to_g2");
      step(DONE_G2,    E_N,      "g2_to_n2");
      step(DONE_NONE2, E_G,      "n2_to_g3");
      step(DONE_G3,    E_Y,      "g3_to_y");
      step(DONE_Y,     E_R,      "y_to_r");
      step(DONE_R,     E_G | RD, "r_to_g1");
      tick();
      check("red_done_single", outs(), E_G);
      done_state = '0;
      tick();

      // Foreign bit and level-high bit are ignored
      done_state[DONE_G2] = 1'b1;
      tick();
      check("foreign_bit", outs(), E_G);
      step(DONE_G1,    E_N, "g1_to_n1_b");
      step(DONE_NONE1, E_G, "n1_to_g2_b");
      tick();
      tick();
      check("level_no_adv", outs(), E_G);
      done_state[DONE_G2] = 1'b0;
      tick();
      check("fall_no_adv", outs(), E_G);
      step(DONE_G2,    E_N, "g2_to_n2_b");
      step(DONE_NONE2, E_G, "n2_to_g3_b");
      step(DONE_G3,    E_Y, "g3_to_y_b");

      // Pass in Y restarts, pass in G1 ignored
      pass = 1'b1;
      tick();
      pass = 1'b0;
      check("pass_in_y", outs(), E_G | RST | RD);
      tick();
      check("pass_pulse_end", outs(), E_G);
      done_state = '0;
      tick();
      pass = 1'b1;
      tick();
      check("pass_in_g1", outs(), E_G);
      tick();
      check("pass_in_g1_hold", outs(), E_G);
      pass = 1'b0;

      // DONE_R edge and pass together
      step(DONE_G1,    E_N, "g1_to_n1_c");
      step(DONE_NONE1, E_G, "n1_to_g2_c");
      step(DONE_G2,    E_N, "g2_to_n2_c");
      step(DONE_NONE2, E_G, "n2_to_g3_c");
      step(DONE_G3,    E_Y, "g3_to_y_c");
      step(DONE_Y,     E_R, "y_to_r_c");
      done_state[DONE_R] = 1'b1;
      pass = 1'b1;
      tick();
      pass = 1'b0;
      check("r_edge_and_pass", outs(), E_G | RST | RD);
      tick();
      check("no_double_entry", outs(), E_G);
      done_state = '0;
      tick();

      // Reset mid-G2
      step(DONE_G1,    E_N, "g1_to_n1_d");
      step(DONE_NONE1, E_G, "n1_to_g2_d");
      reset      = 1'b1;
      done_state = '0;
      tick();
      reset = 1'b0;
      check("reset_mid_g2", outs(), E_G | RST);
      tick();
      check("reset_mid_g2_after", outs(), E_G);

      // Watchdog: DONE_Y already high on entry to Y
      step(DONE_G1,    E_N, "g1_to_n1_e");
      step(DONE_NONE1, E_G, "n1_to_g2_e");
      step(DONE_G2,    E_N, "g2_to_n2_e");
      step(DONE_NONE2, E_G, "n2_to_g3_e");
      done_state[DONE_Y] = 1'b1;
      tick();
      check("y_bit_in_g3", outs(), E_G);
      step(DONE_G3, E_Y, "g3_to_y_e");
      repeat (2046) tick();
      check("wdog_2046", outs(), E_Y);
      tick();
      check("wdog_2047", outs(), E_Y);
      tick();
      check("fault_entry", outs() & ~RST, E_R | FLT);
      pass = 1'b1;
      done_state[DONE_Y] = 1'b0;
      tick();
      done_state[DONE_Y] = 1'b1;
      done_state[DONE_R] = 1'b1;
      tick();
      check("fault_sticky", outs(), E_R | FLT);
      pass = 1'b0;
      reset      = 1'b1;
      done_state = '0;
      tick();
      check("fault_reset", outs(), E_G | RST);
      reset = 1'b0;
      tick();
      check("fault_reset_after", outs(), E_G);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
